dsm_decimator: RTL and testbench



---
 rtl/dsm_pkg.sv | 29 ++
 rtl/cic_integrator_bank.sv | 44 ++++
 rtl/dsm_decimator.sv | 160 ++++++++++++++++
 tb/tb_dsm_decimator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: shared definitions for the sigma-delta decimator.
//   DATA_W      internal and output datapath width (two's complement)
//   FRAC_W      fractional bits of the Q19.16 output format
//   dsm_state_e comb/output sequencer states
//   q16_mul_sm  sign-magnitude multiply by an unsigned Q16 gain, bits [51:16]
package dsm_pkg;

  localparam int DATA_W = 36;
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMB = 2'd1,
    ST_OUT  = 2'd2,
    ST_GAIN = 2'd3
  } dsm_state_e;

  // Multiplies the magnitude so truncation is symmetric about zero, then
  // restores the sign. Results wider than DATA_W wrap.
  function automatic logic [DATA_W-1:0] q16_mul_sm(input logic [DATA_W-1:0] a,
                                                   input logic [31:0]       gain);
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] res;
    mag = a[DATA_W-1] ? (~a + 1'b1) : a;
    res = DATA_W'(({32'd0, mag} * {{DATA_W{1'b0}}, gain}) >> FRAC_W);
    return a[DATA_W-1] ? (~res + 1'b1) : res;
  endfunction

endpackage

// File: rtl/cic_integrator_bank.sv
// cic_integrator_bank: ORDER cascaded integrators running at the bit rate.
//   clk         system clock
//   rst         synchronous reset, active-high; clears every integrator
//   en_i        advance all integrators on this edge
//   bit_i       modulator bit; 1 -> +1, 0 -> -1
//   last_new_o  value the last integrator takes on this edge (pre-register)
module cic_integrator_bank
  import dsm_pkg::*;
#(
  parameter int ORDER = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] last_new_o
);

  logic [DATA_W-1:0] integ_q [ORDER];
  logic [DATA_W-1:0] integ_d [ORDER];

  // Each stage adds the freshly updated value of the stage before it.
  always_comb begin
    logic [DATA_W-1:0] acc;
    integ_d = integ_q;
    acc     = integ_q[0] + (bit_i ? DATA_W'(1) : {DATA_W{1'b1}});
    integ_d[0] = acc;
    for (int k = 1; k < ORDER; k++) begin
      acc        = integ_q[k] + acc;
      integ_d[k] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
    end else if (en_i) begin
      integ_q <= integ_d;
    end
  end

  assign last_new_o = integ_d[ORDER-1];

endmodule

// File: rtl/dsm_decimator.sv
// dsm_decimator: CIC decimator turning the 1-bit modulator stream back into
// signed Q19.16 samples at 1/R of the bit rate.
//   clk        system clock
//   rst        synchronous reset, active-high
//   bit_in     modulator bit (1 = +1.0, 0 = -1.0), used when bit_en = 1
//   bit_en     bit_in valid this cycle
//   out_data   decimated sample, signed Q19.16
//   out_valid  out_data holds an unconsumed sample
//   out_ready  consumer takes out_data when out_valid && out_ready
//   ovf        sticky: an unconsumed sample was overwritten
// Build option: define DSM_DEC_GAIN_EN to apply the Q16 GAIN to each sample
// (one extra clock of latency).
//
// state | meaning
// IDLE  | waiting for the decimation event
// COMB  | one comb stage per clock, stage index in k
// OUT   | scale comb result; loads output (or hands to GAIN)
// GAIN  | apply GAIN and load output (DSM_DEC_GAIN_EN only)
module dsm_decimator
  import dsm_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int LOG2R = 6,
  parameter int GAIN  = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf
);

  localparam int SHIFT = ORDER * LOG2R - FRAC_W;
  localparam int KW    = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int DLY_N = 2 ** KW;

  if (ORDER < 1 || ORDER > 6 || ORDER * LOG2R < 16 || ORDER * LOG2R > 34 || GAIN < 0)
  begin : g_bad_params
    $error("dsm_decimator: illegal ORDER/LOG2R/GAIN combination");
  end

  dsm_state_e        state_q, state_d;
  logic [LOG2R-1:0]  cnt_q;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic [DATA_W-1:0] dly_q [DLY_N];
  logic [DATA_W-1:0] dly_d [DLY_N];
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] integ_last;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_val;
  logic              load;
  logic              dec_event;

  cic_integrator_bank #(.ORDER(ORDER)) u_integ (
    .clk        (clk),
    .rst        (rst),
    .en_i       (bit_en),
    .bit_i      (bit_in),
    .last_new_o (integ_last)
  );

  assign dec_event = bit_en && (cnt_q == {LOG2R{1'b1}});
  assign shifted   = $signed(s_q) >>> SHIFT;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (bit_en) cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    s_d      = s_q;
    dly_d    = dly_q;
    load     = 1'b0;
    load_val = shifted;
    unique case (state_q)
      ST_IDLE: begin
        if (dec_event) begin
          s_d     = integ_last;
          k_d     = '0;
          state_d = ST_COMB;
        end
      end
      ST_COMB: begin
        s_d        = s_q - dly_q[k_q];
        dly_d[k_q] = s_q;
        k_d        = k_q + 1'b1;
        if (k_q == KW'(ORDER - 1)) state_d = ST_OUT;
      end
`ifdef DSM_DEC_GAIN_EN
      ST_OUT: begin
        s_d     = shifted;
        state_d = ST_GAIN;
      end
      ST_GAIN: begin
        load     = 1'b1;
        load_val = q16_mul_sm(s_q, 32'(GAIN));
        state_d  = ST_IDLE;
      end
`else
      ST_OUT: begin
        load    = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // With the smallest ratios the next event can land on the load clock.
    if (load && dec_event) begin
      s_d     = integ_last;
      k_d     = '0;
      state_d = ST_COMB;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (load) begin
      out_data_d  = load_val;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) ovf_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      s_q         <= '0;
      for (int i = 0; i < DLY_N; i++) dly_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      s_q         <= s_d;
      dly_q       <= dly_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsm_decimator.sv
`timescale 1ns/1ps
module tb_dsm_decimator;

  localparam int ORDER = 3;
  localparam int LOG2R = 6;
  localparam int R     = 64;
  localparam int KLEN  = ORDER * (R - 1) + 1;
  localparam int SHIFT = ORDER * LOG2R - 16;
`ifdef DSM_DEC_GAIN_EN
  localparam int GAIN = 32768;
  localparam int LAT  = ORDER + 2;
  localparam logic [35:0] E_POS   = 36'h0_0000_8000;
  localparam logic [35:0] E_NEG   = 36'hF_FFFF_8000;
  localparam logic [35:0] E_HALF  = 36'h0_0000_4000;
  localparam logic [35:0] E_FIRST = 36'd5720;
`else
  localparam int GAIN = 65536;
  localparam int LAT  = ORDER + 1;
  localparam logic [35:0] E_POS   = 36'h0_0001_0000;
  localparam logic [35:0] E_NEG   = 36'hF_FFFF_0000;
  localparam logic [35:0] E_HALF  = 36'h0_0000_8000;
  localparam logic [35:0] E_FIRST = 36'd11440;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_en = 1'b0;
  logic        out_ready = 1'b1;
  logic [35:0] out_data;
  logic        out_valid;
  logic        ovf;

  dsm_decimator #(.ORDER(ORDER), .LOG2R(LOG2R), .GAIN(GAIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the CIC is a linear filter whose impulse response is
  // ORDER boxcars of length R convolved; each output is that kernel applied
  // to the accepted bits, scaled by 2^-SHIFT (and the gain, when enabled).
  longint h [KLEN];
  longint kern_tmp [KLEN];
  initial begin
    for (int i = 0; i < KLEN; i++) h[i] = 0;
    h[0] = 1;
    repeat (ORDER) begin
      for (int i = 0; i < KLEN; i++) begin
        kern_tmp[i] = 0;
        for (int j = 0; j < R; j++) if (i - j >= 0) kern_tmp[i] += h[i-j];
      end
      h = kern_tmp;
    end
  end

  bit hist[$];

  typedef struct {
    int unsigned due;
    logic [35:0] val;
  } pend_t;
  pend_t pend[$];

  function automatic logic [35:0] model_sample();
    longint acc;
    longint mag;
    longint p;
    int n;
    n   = hist.size();
    acc = 0;
    for (int j = 0; j < KLEN; j++)
      if (n - 1 - j >= 0) acc += h[j] * (hist[n-1-j] ? 1 : -1);
    acc = acc >>> SHIFT;
`ifdef DSM_DEC_GAIN_EN
    mag = (acc < 0) ? -acc : acc;
    p   = (mag * GAIN) >>> 16;
    acc = (acc < 0) ? -p : p;
`else
    mag = 0;
    p   = 0;
`endif
    return acc[35:0];
  endfunction

  int unsigned cyc = 0;
  logic [35:0] m_data = '0;
  bit          m_valid = 0;
  bit          m_ovf = 0;
  bit          m_load;
  logic [35:0] m_nv;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      hist.delete();
      pend.delete();
      m_data  = '0;
      m_valid = 0;
      m_ovf   = 0;
    end else begin
      m_load = 0;
      m_nv   = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_load = 1;
        m_nv   = pend[0].val;
        void'(pend.pop_front());
      end
      if (m_load) begin
        if (m_valid && !out_ready) m_ovf = 1;
        m_data  = m_nv;
        m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (bit_en) begin
        hist.push_back(bit_in);
        if (hist.size() % R == 0) pend.push_back('{due: cyc + LAT, val: model_sample()});
      end
    end
  end

  // Per-cycle comparison against the model, plus output bookkeeping.
  bit          prev_valid = 0;
  bit          cap_first = 0;
  int          n_out = 0;
  logic [35:0] dut_last = '0;
  logic [35:0] first_out = '0;

  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
    if (m_valid) chk("out_data", {28'd0, out_data}, {28'd0, m_data});
    if (out_valid && !prev_valid) begin
      n_out++;
      if (cap_first) begin
        first_out = out_data;
        cap_first = 0;
      end
    end
    if (out_valid) dut_last = out_data;
    prev_valid = out_valid;
  end

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    bit_en = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    n_out = 0;
  endtask

  task automatic drive_pat(input logic [3:0] pat, input int plen, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      bit_en = 1'b1;
      bit_in = pat[i % plen];
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bit_en = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic steady_case(input string name, input logic [3:0] pat, input int plen,
                             input logic [35:0] exp);
    do_reset();
    drive_pat(pat, plen, 6 * R);
    idle(LAT + 3);
    chk({name, "_dut"}, {28'd0, dut_last}, {28'd0, exp});
    chk({name, "_model"}, {28'd0, m_data}, {28'd0, exp});
    chk({name, "_count"}, 64'(n_out), 64'd6);
    chk({name, "_ovf"}, {63'd0, ovf}, 64'd0);
  endtask

  logic [35:0] pwr_first;
  int lat_n;
  int acc_bits;
  int guard;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_data", {28'd0, out_data}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);

    // First output after power-up: latency and zero-state transient.
    cap_first = 1;
    drive_pat(4'b1111, 1, R);
    @(negedge clk);
    bit_en = 1'b0;
    lat_n  = 0;
    while (!out_valid && lat_n < 20) begin
      @(negedge clk);
      lat_n++;
    end
    chk("latency", 64'(lat_n), 64'(LAT));
    @(negedge clk);
    chk("first_out_dut", {28'd0, first_out}, {28'd0, E_FIRST});
    chk("first_out_model", {28'd0, m_data}, {28'd0, E_FIRST});
    pwr_first = first_out;

    steady_case("ones", 4'b1111, 1, E_POS);
    steady_case("zeros", 4'b0000, 1, E_NEG);
    steady_case("alt", 4'b0101, 2, 36'd0);
    steady_case("p1110", 4'b0111, 4, E_HALF);

    // Consumer stalls for three decimation periods.
    do_reset();
    drive_pat(4'b1111, 1, 4 * R);
    out_ready = 1'b0;
    drive_pat(4'b1111, 1, 3 * R);
    idle(LAT + 3);
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    chk("stall_ovf", {63'd0, ovf}, 64'd1);
    chk("stall_data", {28'd0, out_data}, {28'd0, E_POS});
    out_ready = 1'b1;
    drive_pat(4'b1111, 1, R);
    idle(LAT + 3);
    chk("ovf_sticky", {63'd0, ovf}, 64'd1);
    do_reset();
    chk("ovf_cleared", {63'd0, ovf}, 64'd0);

    // Sparse bit_en, all ones.
    do_reset();
    acc_bits = 0;
    guard    = 0;
    while (acc_bits < 6 * R && guard < 20000) begin
      @(negedge clk);
      bit_in = 1'b1;
      bit_en = ($urandom_range(0, 99) < 30);
      if (bit_en) acc_bits++;
      guard++;
    end
    chk("rand_bits", 64'(acc_bits), 64'(6 * R));
    idle(LAT + 3);
    chk("rand_dut", {28'd0, dut_last}, {28'd0, E_POS});
    chk("rand_count", 64'(n_out), 64'd6);

    // Reset while the comb sequence is running (out_data currently nonzero).
    drive_pat(4'b1111, 1, R);
    @(negedge clk);
    bit_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data", {28'd0, out_data}, 64'd0);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ovf", {63'd0, ovf}, 64'd0);
    rst       = 1'b0;
    n_out     = 0;
    cap_first = 1;
    idle(10);
    chk("midrst_no_output", 64'(n_out), 64'd0);
    drive_pat(4'b1111, 1, R);
    idle(LAT + 3);
    chk("midrst_first", {28'd0, first_out}, {28'd0, pwr_first});
    chk("midrst_first_lit", {28'd0, first_out}, {28'd0, E_FIRST});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
